// File: rtl/filtro_fir_serial.sv
// Serial FIR filter stage. It takes samples from the ADC capture chain and computes
// y[n] = sum h[k]*x[n-k] with a single shared multiplier, one tap per clock.
// Optional build macro: FIR_ROUND_EN selects round-half-up before saturation.
// Without it the result is truncated toward -inf.
module filtro_fir_serial #(
    parameter int unsigned           Width     = 22,
    parameter int unsigned           FRAC_BITS = 10,
    parameter int unsigned           TAPS      = 4,
    parameter logic [TAPS*Width-1:0] COEFS     = {4{22'd256}}
) (
    input  logic                    clk100MHz,
    input  logic                    reset,
    input  logic                    listo_adc,
    input  logic signed [Width-1:0] dato_adc,
    output logic signed [Width-1:0] y,
    output logic                    y_valid,
    output logic                    ocupado,
    output logic                    overrun
);

    localparam int unsigned KW    = $clog2(TAPS);
    localparam int unsigned ProdW = 2 * Width;
    // Headroom of clog2(TAPS) bits keeps the accumulator from ever wrapping
    localparam int unsigned AccW  = ProdW + KW;

    localparam logic [KW-1:0] KMax = KW'(TAPS - 1);

    localparam logic signed [AccW-1:0] YMax = {{(AccW-Width+1){1'b0}}, {(Width-1){1'b1}}};
    localparam logic signed [AccW-1:0] YMin = {{(AccW-Width+1){1'b1}}, {(Width-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StShift, StMac, StSat} state_e;

    state_e state_q, state_d;

    logic sync1_q, sync2_q, sync3_q;
    logic nueva;

    logic signed [Width-1:0] x_q [TAPS];
    logic signed [Width-1:0] coef [TAPS];
    logic signed [AccW-1:0]  acc_q;
    logic        [KW-1:0]    k_q;

    logic signed [Width-1:0] x_sel;
    logic signed [Width-1:0] h_sel;
    logic signed [ProdW-1:0] prod;
    logic signed [AccW-1:0]  prod_ext;
    logic signed [AccW-1:0]  acc_adj;
    logic signed [AccW-1:0]  shifted;
    logic signed [Width-1:0] sat_val;

    logic signed [Width-1:0] y_q;
    logic                    y_valid_q;
    logic                    overrun_q;

    // Unpack the coefficient vector so the MAC can index it by tap.
    for (genvar g = 0; g < TAPS; g++) begin : g_coef
        assign coef[g] = COEFS[g*Width +: Width];
    end

    // Two-flop synchronizer for the ADC ready level, plus one extra flop for edge detection.
    always_ff @(posedge clk100MHz or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= listo_adc;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign nueva = sync2_q & ~sync3_q;

    // FSM state register.
    always_ff @(posedge clk100MHz or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: IDLE -> SHIFT -> MAC (TAPS cycles) -> SAT -> IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (nueva) state_d = StShift;
            StShift: state_d = StMac;
            StMac:   if (k_q == KMax) state_d = StSat;
            StSat:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Shared multiplier operand selection and sign extension into accumulator width.
    always_comb begin
        x_sel    = x_q[k_q];
        h_sel    = coef[k_q];
        prod     = x_sel * h_sel;
        prod_ext = {{KW{prod[ProdW-1]}}, prod};
    end

`ifdef FIR_ROUND_EN
    localparam logic signed [AccW-1:0] Half = AccW'(1) << (FRAC_BITS - 1);
    assign acc_adj = acc_q + Half;
`else
    assign acc_adj = acc_q;
`endif

    // Rescale from Q.FRAC_BITS and clamp to the output range.
    always_comb begin
        shifted = acc_adj >>> FRAC_BITS;
        if (shifted > YMax) begin
            sat_val = YMax[Width-1:0];
        end else if (shifted < YMin) begin
            sat_val = YMin[Width-1:0];
        end else begin
            sat_val = shifted[Width-1:0];
        end
    end

    // Delay line, accumulator and tap counter.
    always_ff @(posedge clk100MHz or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
            acc_q <= '0;
            k_q   <= '0;
        end else begin
            case (state_q)
                StShift: begin
                    for (int i = TAPS - 1; i > 0; i--) x_q[i] <= x_q[i-1];
                    x_q[0] <= dato_adc;
                    acc_q  <= '0;
                    k_q    <= '0;
                end
                StMac: begin
                    acc_q <= acc_q + prod_ext;
                    k_q   <= k_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output register, one-cycle valid pulse and sticky overrun flag.
    always_ff @(posedge clk100MHz or negedge reset) begin
        if (!reset) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            y_valid_q <= (state_q == StSat);
            if (state_q == StSat) y_q <= sat_val;
            // An edge that arrives while busy (SAT included) is dropped.
            if (nueva && (state_q != StIdle)) overrun_q <= 1'b1;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign overrun = overrun_q;
    assign ocupado = (state_q != StIdle);

endmodule
